// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-register hazard inputs and the
// stall/flush/enable controls returned to the 5-stage datapath.
interface pipe_hazard_ctrl_if;
  logic [2:0]  rs_IFID;
  logic [2:0]  rt_IFID;
  logic        rsUsed;
  logic        rtUsed;
  logic        halt_IFID;
  logic [2:0]  WrR_IDEX;
  logic        RegWrite_IDEX;
  logic [2:0]  WrR_EXMEM;
  logic        RegWrite_EXMEM;
  logic [2:0]  WrR_MEMWB;
  logic        RegWrite_MEMWB;
  logic        takeBranch_EXMEM;
  logic        memBusy;
  logic        pc_en;
  logic        ifid_en;
  logic        stallCtrl;
  logic        flush_IFID;
  logic        flush_IDEX;
  logic        pipe_en;
  logic        halted;
  logic        err;
  logic [15:0] stallCount;
  logic [15:0] flushCount;

  modport master (
    output rs_IFID, rt_IFID, rsUsed, rtUsed,
    output halt_IFID,
    output WrR_IDEX, RegWrite_IDEX,
    output WrR_EXMEM, RegWrite_EXMEM,
    output WrR_MEMWB, RegWrite_MEMWB,
    output takeBranch_EXMEM, memBusy,
    input  pc_en, ifid_en, stallCtrl,
    input  flush_IFID, flush_IDEX, pipe_en,
    input  halted, err,
    input  stallCount, flushCount
  );

  modport slave (
    input  rs_IFID, rt_IFID, rsUsed, rtUsed,
    input  halt_IFID,
    input  WrR_IDEX, RegWrite_IDEX,
    input  WrR_EXMEM, RegWrite_EXMEM,
    input  WrR_MEMWB, RegWrite_MEMWB,
    input  takeBranch_EXMEM, memBusy,
    output pc_en, ifid_en, stallCtrl,
    output flush_IFID, flush_IDEX, pipe_en,
    output halted, err,
    output stallCount, flushCount
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: decode-stage stall/flush sequencer for the 5-stage core.
// RAW interlock, branch squash, memory freeze, halt drain, perf counters.
module pipe_hazard_ctrl #(
  parameter bit RF_BYPASS    = 1'b0,
  parameter int DRAIN_CYCLES = 3,
  parameter int STALL_MAX    = 64
) (
  input logic               clk,
  input logic               rst,
  pipe_hazard_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN, STALL, DRAIN, HALTED
  } state_e;

  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam int SW = $clog2(STALL_MAX + 1);

  state_e        state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [SW-1:0] run_q, run_d;
  logic [15:0]   scnt_q, scnt_d;
  logic [15:0]   fcnt_q, fcnt_d;
  logic          err_q, err_d;

  logic hz_ie, hz_em, hz_mw, hazard;
  logic pc_en, ifid_en, stall_ctrl;
  logic flush, pipe_en;

  function automatic logic hit(
    input logic [2:0] wr,
    input logic       we,
    input logic [2:0] rs,
    input logic [2:0] rt,
    input logic       rsu,
    input logic       rtu
  );
    return we & ((rsu & (rs == wr)) |
                 (rtu & (rt == wr)));
  endfunction

  function automatic logic [15:0] sat(
    input logic [15:0] x
  );
    return (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  assign hz_ie = hit(bus.WrR_IDEX, bus.RegWrite_IDEX,
                     bus.rs_IFID, bus.rt_IFID,
                     bus.rsUsed, bus.rtUsed);
  assign hz_em = hit(bus.WrR_EXMEM, bus.RegWrite_EXMEM,
                     bus.rs_IFID, bus.rt_IFID,
                     bus.rsUsed, bus.rtUsed);
  assign hz_mw = hit(bus.WrR_MEMWB, bus.RegWrite_MEMWB,
                     bus.rs_IFID, bus.rt_IFID,
                     bus.rsUsed, bus.rtUsed);

  // With a bypassing register file the MEM/WB writer is already visible.
  assign hazard = ~bus.takeBranch_EXMEM &
                  (hz_ie | hz_em |
                   (RF_BYPASS ? 1'b0 : hz_mw));

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    run_d      = run_q;
    scnt_d     = scnt_q;
    fcnt_d     = fcnt_q;
    err_d      = err_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    pipe_en    = 1'b0;
    stall_ctrl = 1'b1;
    flush      = 1'b0;
    if (!rst || state_q == HALTED) begin
      pipe_en = 1'b0;
    end else if (bus.memBusy) begin
      stall_ctrl = 1'b0;
    end else if (bus.takeBranch_EXMEM) begin
      pipe_en = 1'b1;
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      flush   = 1'b1;
      fcnt_d  = sat(fcnt_q);
      state_d = RUN;
      run_d   = '0;
      drain_d = '0;
    end else if (state_q == DRAIN) begin
      pipe_en = 1'b1;
      drain_d = drain_q + 1'b1;
      if (drain_d == DW'(DRAIN_CYCLES))
        state_d = HALTED;
    end else if (hazard) begin
      pipe_en = 1'b1;
      scnt_d  = sat(scnt_q);
      state_d = STALL;
      run_d   = (run_q == SW'(STALL_MAX)) ?
                run_q : run_q + 1'b1;
      if (run_d == SW'(STALL_MAX))
        err_d = 1'b1;
    end else if (bus.halt_IFID) begin
      pipe_en = 1'b1;
      drain_d = DW'(1);
      run_d   = '0;
      state_d = (DRAIN_CYCLES <= 1) ?
                HALTED : DRAIN;
    end else begin
      pipe_en    = 1'b1;
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      stall_ctrl = 1'b0;
      run_d      = '0;
      state_d    = RUN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drain_q <= '0;
      run_q   <= '0;
      scnt_q  <= '0;
      fcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      run_q   <= run_d;
      scnt_q  <= scnt_d;
      fcnt_q  <= fcnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.pc_en      = pc_en;
  assign bus.ifid_en    = ifid_en;
  assign bus.pipe_en    = pipe_en;
  assign bus.stallCtrl  = stall_ctrl;
  assign bus.flush_IFID = flush;
  assign bus.flush_IDEX = flush;
  assign bus.halted     = (state_q == HALTED);
  assign bus.err        = err_q;
  assign bus.stallCount = scnt_q;
  assign bus.flushCount = fcnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors with a per-cycle scoreboard.
// u0 has RF_BYPASS=0, u1 has RF_BYPASS=1; both see the same inputs.
module tb_pipe_hazard_ctrl;
  logic clk;
  logic rst;

  logic [2:0] rs, rt, wi, wx, wm;
  logic       rsu, rtu, hlt;
  logic       wei, wex, wem, br, busy;

  pipe_hazard_ctrl_if b0 ();
  pipe_hazard_ctrl_if b1 ();

  assign b0.rs_IFID = rs;
  assign b0.rt_IFID = rt;
  assign b0.rsUsed = rsu;
  assign b0.rtUsed = rtu;
  assign b0.halt_IFID = hlt;
  assign b0.WrR_IDEX = wi;
  assign b0.RegWrite_IDEX = wei;
  assign b0.WrR_EXMEM = wx;
  assign b0.RegWrite_EXMEM = wex;
  assign b0.WrR_MEMWB = wm;
  assign b0.RegWrite_MEMWB = wem;
  assign b0.takeBranch_EXMEM = br;
  assign b0.memBusy = busy;

  assign b1.rs_IFID = rs;
  assign b1.rt_IFID = rt;
  assign b1.rsUsed = rsu;
  assign b1.rtUsed = rtu;
  assign b1.halt_IFID = hlt;
  assign b1.WrR_IDEX = wi;
  assign b1.RegWrite_IDEX = wei;
  assign b1.WrR_EXMEM = wx;
  assign b1.RegWrite_EXMEM = wex;
  assign b1.WrR_MEMWB = wm;
  assign b1.RegWrite_MEMWB = wem;
  assign b1.takeBranch_EXMEM = br;
  assign b1.memBusy = busy;

  pipe_hazard_ctrl #(.RF_BYPASS(1'b0)) u0 (
    .clk(clk), .rst(rst), .bus(b0)
  );
  pipe_hazard_ctrl #(.RF_BYPASS(1'b1)) u1 (
    .clk(clk), .rst(rst), .bus(b1)
  );

  typedef struct {
    string       nm;
    int          dut;
    logic        pc;
    int          ifd;
    logic        sc;
    logic        fl;
    logic        pe;
    logic        hl;
    logic        er;
    logic [15:0] scnt;
    logic [15:0] fcnt;
  } exp_t;

  exp_t q[$];
  int ntests = 0;
  int nfail  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t sample(input int d);
    exp_t a;
    a.nm  = "";
    a.dut = d;
    if (d == 0) begin
      a.pc   = b0.pc_en;
      a.ifd  = int'(b0.ifid_en);
      a.sc   = b0.stallCtrl;
      a.fl   = b0.flush_IFID & b0.flush_IDEX;
      if (b0.flush_IFID != b0.flush_IDEX) a.fl = 1'bx;
      a.pe   = b0.pipe_en;
      a.hl   = b0.halted;
      a.er   = b0.err;
      a.scnt = b0.stallCount;
      a.fcnt = b0.flushCount;
    end else begin
      a.pc   = b1.pc_en;
      a.ifd  = int'(b1.ifid_en);
      a.sc   = b1.stallCtrl;
      a.fl   = b1.flush_IFID & b1.flush_IDEX;
      if (b1.flush_IFID != b1.flush_IDEX) a.fl = 1'bx;
      a.pe   = b1.pipe_en;
      a.hl   = b1.halted;
      a.er   = b1.err;
      a.scnt = b1.stallCount;
      a.fcnt = b1.flushCount;
    end
    return a;
  endfunction

  // Monitor: every queued expectation belongs to the current cycle.
  always @(negedge clk) begin : mon
    exp_t e, a;
    bit   ok;
    while (q.size() > 0) begin
      e  = q.pop_front();
      a  = sample(e.dut);
      ok = (a.pc === e.pc) && (a.sc === e.sc) &&
           (a.fl === e.fl) && (a.pe === e.pe) &&
           (a.hl === e.hl) && (a.er === e.er) &&
           (a.scnt === e.scnt) &&
           (a.fcnt === e.fcnt) &&
           (e.ifd < 0 || a.ifd == e.ifd);
      ntests++;
      if (!ok) begin
        nfail++;
        $display("FAIL %s dut%0d: got pc=%b ifid=%0d sc=%b fl=%b pe=%b h=%b e=%b sn=%0d fn=%0d want pc=%b ifid=%0d sc=%b fl=%b pe=%b h=%b e=%b sn=%0d fn=%0d",
          e.nm, e.dut, a.pc, a.ifd, a.sc, a.fl, a.pe,
          a.hl, a.er, a.scnt, a.fcnt, e.pc, e.ifd,
          e.sc, e.fl, e.pe, e.hl, e.er, e.scnt, e.fcnt);
      end
    end
  end

  task automatic clr();
    rs = 3'd0; rt = 3'd0; rsu = 1'b0; rtu = 1'b0;
    hlt = 1'b0; br = 1'b0; busy = 1'b0;
    wi = 3'd0; wx = 3'd0; wm = 3'd0;
    wei = 1'b0; wex = 1'b0; wem = 1'b0;
  endtask

  task automatic cyc(
    input string nm, input int d,
    input logic pc, input int ifd, input logic sc,
    input logic fl, input logic pe, input logic hl,
    input logic er, input int sn, input int fn
  );
    exp_t e;
    e.nm = nm; e.dut = d; e.pc = pc; e.ifd = ifd;
    e.sc = sc; e.fl = fl; e.pe = pe; e.hl = hl;
    e.er = er; e.scnt = 16'(sn); e.fcnt = 16'(fn);
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr();
    cyc("reset", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    clr();
    @(posedge clk);
    #1;

    // T1: r3 writer walks IDEX -> EXMEM -> MEMWB
    do_reset();
    cyc("idle_run", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);
    rs = 3'd3; rsu = 1'b1; wi = 3'd3; wei = 1'b1;
    cyc("t1_idex", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    wei = 1'b0; wx = 3'd3; wex = 1'b1;
    cyc("t1_exmem", 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    wex = 1'b0; wm = 3'd3; wem = 1'b1;
    cyc("t1_memwb", 0, 0, 0, 1, 0, 1, 0, 0, 2, 0);
    wem = 1'b0;
    cyc("t1_resume", 0, 1, 1, 0, 0, 1, 0, 0, 3, 0);

    // T2: bypassing register file, checked on u1
    do_reset();
    rs = 3'd3; rsu = 1'b1; wi = 3'd3; wei = 1'b1;
    cyc("t2_idex", 1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    wei = 1'b0; wx = 3'd3; wex = 1'b1;
    cyc("t2_exmem", 1, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    wex = 1'b0; wm = 3'd3; wem = 1'b1;
    cyc("t2_memwb", 1, 1, 1, 0, 0, 1, 0, 0, 2, 0);
    clr();
    rs = 3'd5; rsu = 1'b1; rt = 3'd3; rtu = 1'b0;
    wi = 3'd3; wei = 1'b1;
    cyc("t2_rt_unused", 1, 1, 1, 0, 0, 1, 0, 0, 2, 0);
    rtu = 1'b1;
    cyc("t2_rt_used", 1, 0, 0, 1, 0, 1, 0, 0, 2, 0);

    // T3: taken branch beats a hazard
    do_reset();
    rs = 3'd3; rsu = 1'b1; wi = 3'd3; wei = 1'b1;
    br = 1'b1;
    cyc("t3_flush", 0, 1, -1, 1, 1, 1, 0, 0, 0, 0);
    clr();
    cyc("t3_after", 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
    rs = 3'd4; rsu = 1'b1; wx = 3'd4; wex = 1'b1;
    cyc("t3_stall", 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    br = 1'b1;
    cyc("t3_flush_stall", 0, 1, -1, 1, 1, 1, 0, 0, 1, 1);
    clr();
    cyc("t3_run", 0, 1, 1, 0, 0, 1, 0, 0, 1, 2);

    // T4: halt drain then sticky halted
    do_reset();
    hlt = 1'b1;
    cyc("t4_accept", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("t4_drain1", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("t4_drain2", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    clr();
    for (int i = 0; i < 100; i++) begin
      rs = 3'd3; wi = 3'd3; wei = 1'b1;
      rsu = (i % 2 == 0);
      cyc("t4_halted", 0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
    end

    // T4 variant: taken branch cancels the drain
    do_reset();
    hlt = 1'b1;
    cyc("t4v_accept", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    cyc("t4v_drain1", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    hlt = 1'b0; br = 1'b1;
    cyc("t4v_branch", 0, 1, -1, 1, 1, 1, 0, 0, 0, 0);
    clr();
    cyc("t4v_run", 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);
    cyc("t4v_run2", 0, 1, 1, 0, 0, 1, 0, 0, 0, 1);

    // T5: memory busy freezes a stall
    do_reset();
    rs = 3'd2; rsu = 1'b1; wi = 3'd2; wei = 1'b1;
    cyc("t5_stall", 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    busy = 1'b1;
    for (int i = 0; i < 5; i++)
      cyc("t5_busy", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    busy = 1'b0;
    cyc("t5_idex", 0, 0, 0, 1, 0, 1, 0, 0, 1, 0);
    wei = 1'b0; wx = 3'd2; wex = 1'b1;
    cyc("t5_exmem", 0, 0, 0, 1, 0, 1, 0, 0, 2, 0);
    wex = 1'b0; wm = 3'd2; wem = 1'b1;
    cyc("t5_memwb", 0, 0, 0, 1, 0, 1, 0, 0, 3, 0);
    wem = 1'b0;
    cyc("t5_resume", 0, 1, 1, 0, 0, 1, 0, 0, 4, 0);

    // T6: watchdog, then asynchronous reset mid-stall
    do_reset();
    rs = 3'd6; rsu = 1'b1; wi = 3'd6; wei = 1'b1;
    for (int i = 1; i <= 64; i++)
      cyc("t6_stall", 0, 0, 0, 1, 0, 1, 0, 0, i - 1, 0);
    cyc("t6_err", 0, 0, 0, 1, 0, 1, 0, 1, 64, 0);
    cyc("t6_err_hold", 0, 0, 0, 1, 0, 1, 0, 1, 65, 0);
    rst = 1'b0;
    cyc("t6_async_rst", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    clr();
    cyc("t6_run", 0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

    @(negedge clk);
    @(negedge clk);
    ntests++;
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
